// File: rtl/uart_tx_controller.sv
// uart_tx_controller: memory-mapped 8N1 UART transmitter with a byte FIFO.
//
// Ports:
//   clk_in              CPU clock
//   rst_in              synchronous active-high reset
//   cpu_addr_in         byte address, only [3:2] decoded (0 DATA, 1 STATUS, 2/3 reserved)
//   cpu_data_in         write data (DATA: [7:0] byte, STATUS: [3] clears overflow)
//   cpu_write_enable_in byte strobes, only bit 0 used
//   cpu_data_out        registered read data, one cycle latency
//   uart_tx_out         serial line, idle high
//   busy_out            registered: FIFO non-empty or frame in progress
//
// STATUS: [0] full, [1] empty, [2] shifter active, [3] sticky overflow,
//         [4 +: $clog2(FIFO_DEPTH)+1] FIFO count.
module uart_tx_controller #(
   parameter int unsigned CLOCK_FREQ = 50_000_000,
   parameter int unsigned BAUD_RATE  = 115_200,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] cpu_addr_in,
   input  logic [31:0] cpu_data_in,
   input  logic [3:0]  cpu_write_enable_in,
   output logic [31:0] cpu_data_out,
   output logic        uart_tx_out,
   output logic        busy_out
);

   localparam int unsigned CYCLES_PER_BIT = CLOCK_FREQ / BAUD_RATE;
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned BCNT_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
   localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(CYCLES_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

   state_t              state_q, state_d;
   logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
   logic [2:0]          bidx_q, bidx_d;
   logic [7:0]          sr_q, sr_d;
   logic                tx_q, tx_d;
   logic                busy_q, busy_d;
   logic                ovf_q, ovf_d;
   logic [31:0]         rdata_q, rdata_d;
   logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [7:0]          mem [FIFO_DEPTH];

   logic [1:0]  sel;
   logic        full, empty, pop, push_req, push_ok, ovf_set, ovf_clr;
   logic [7:0]  head;
   logic [31:0] status;

   // Bits outside the decoded bus fields are intentionally ignored.
   logic unused_bus;
   assign unused_bus = ^{cpu_addr_in[31:4], cpu_addr_in[1:0], cpu_data_in[31:8],
                         cpu_write_enable_in[3:1]};

   assign sel   = cpu_addr_in[3:2];
   assign full  = (count_q == CNT_FULL);
   assign empty = (count_q == '0);
   assign head  = mem[rptr_q];

   // Bus side: push, overflow and status snapshot (taken before this cycle's push/pop).
   always_comb begin
      push_req = cpu_write_enable_in[0] && (sel == 2'd0);
      // A full FIFO still accepts a push when the serializer pops in the same cycle.
      push_ok  = push_req && (!full || pop);
      ovf_set  = push_req && full && !pop;
      ovf_clr  = cpu_write_enable_in[0] && (sel == 2'd1) && cpu_data_in[3];
      ovf_d    = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

      wptr_d = push_ok ? wptr_q + PTR_W'(1) : wptr_q;
      rptr_d = pop ? rptr_q + PTR_W'(1) : rptr_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      status            = '0;
      status[0]         = full;
      status[1]         = empty;
      status[2]         = (state_q != StIdle);
      status[3]         = ovf_q;
      status[4 +: CNT_W] = count_q;
      rdata_d = (sel == 2'd1) ? status : 32'h0;

      busy_d = !empty || (state_q != StIdle);
   end

   // Serializer next-state; the line is registered from the current state, so it
   // trails the state by one cycle uniformly and frames stay gapless.
   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      bidx_d  = bidx_q;
      sr_d    = sr_q;
      pop     = 1'b0;
      tx_d    = 1'b1;
      unique case (state_q)
         StIdle: begin
            if (!empty) begin
               pop     = 1'b1;
               sr_d    = head;
               bcnt_d  = '0;
               state_d = StStart;
            end
         end
         StStart: begin
            tx_d = 1'b0;
            if (bcnt_q == BCNT_LAST) begin
               bcnt_d  = '0;
               bidx_d  = 3'd0;
               state_d = StData;
            end else begin
               bcnt_d = bcnt_q + BCNT_W'(1);
            end
         end
         StData: begin
            tx_d = sr_q[bidx_q];
            if (bcnt_q == BCNT_LAST) begin
               bcnt_d = '0;
               if (bidx_q == 3'd7) begin
                  state_d = StStop;
               end else begin
                  bidx_d = bidx_q + 3'd1;
               end
            end else begin
               bcnt_d = bcnt_q + BCNT_W'(1);
            end
         end
         StStop: begin
            tx_d = 1'b1;
            if (bcnt_q == BCNT_LAST) begin
               bcnt_d = '0;
               if (!empty) begin
                  pop     = 1'b1;
                  sr_d    = head;
                  state_d = StStart;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               bcnt_d = bcnt_q + BCNT_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= StIdle;
         bcnt_q  <= '0;
         bidx_q  <= '0;
         sr_q    <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
         rdata_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         bidx_q  <= bidx_d;
         sr_q    <= sr_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
         rdata_q <= rdata_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge clk_in) begin
      if (push_ok && !rst_in) begin
         mem[wptr_q] <= cpu_data_in[7:0];
      end
   end

   assign cpu_data_out = rdata_q;
   assign uart_tx_out  = tx_q;
   assign busy_out     = busy_q;

endmodule

// File: tb/tb_uart_tx_controller.sv
module tb_uart_tx_controller;

   localparam int CPB   = 10;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] cpu_addr = 32'h0;
   logic [31:0] cpu_wdata = 32'h0;
   logic [3:0]  cpu_we = 4'h0;
   logic [31:0] cpu_rdata;
   logic        txd;
   logic        busy;

   int checks = 0;
   int failures = 0;
   int unsigned cyc = 0;

   logic [7:0]  rx_q[$];
   int unsigned rx_start[$];
   int          rx_err = 0;
   logic [7:0]  rx_byte;
   logic        rx_start_ok;

   uart_tx_controller #(
      .CLOCK_FREQ(1000),
      .BAUD_RATE (100),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk_in             (clk),
      .rst_in             (rst),
      .cpu_addr_in        (cpu_addr),
      .cpu_data_in        (cpu_wdata),
      .cpu_write_enable_in(cpu_we),
      .cpu_data_out       (cpu_rdata),
      .uart_tx_out        (txd),
      .busy_out           (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Line receiver: samples mid-bit on negedges, queues decoded bytes and start cycles.
   always begin
      @(negedge clk);
      if (!rst && txd === 1'b0) begin
         rx_start.push_back(cyc);
         repeat (CPB / 2) @(negedge clk);
         rx_start_ok = (txd === 1'b0);
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            rx_byte[i] = txd;
         end
         repeat (CPB) @(negedge clk);
         if (!rx_start_ok || txd !== 1'b1) rx_err++;
         rx_q.push_back(rx_byte);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [1:0] sel, input logic [31:0] data, input logic [3:0] we);
      logic [31:0] a;
      a = $urandom;
      a[3:2] = sel;
      cpu_addr = a;
      cpu_wdata = data;
      cpu_we = we;
      @(posedge clk);
      #1;
      cpu_we = 4'h0;
      cpu_wdata = $urandom;
   endtask

   task automatic bus_read(input logic [1:0] sel, output logic [31:0] data);
      logic [31:0] a;
      a = $urandom;
      a[3:2] = sel;
      cpu_addr = a;
      cpu_we = 4'h0;
      @(posedge clk);
      #1;
      data = cpu_rdata;
   endtask

   task automatic wait_idle(input int budget, output bit timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < budget; i++) begin
         tick(1);
         if (busy === 1'b0) begin
            timed_out = 1'b0;
            break;
         end
      end
      tick(5);
   endtask

   task automatic clear_rx();
      rx_q.delete();
      rx_start.delete();
      rx_err = 0;
   endtask

   task automatic test_reset();
      logic [31:0] s;
      rst = 1'b1;
      cpu_we = 4'h0;
      tick(3);
      checks++;
      if (txd !== 1'b1) begin
         failures++;
         $display("FAIL reset_tx: got %b expected 1", txd);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy: got %b expected 0", busy);
      end
      checks++;
      if (cpu_rdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_rdata: got %h expected 0", cpu_rdata);
      end
      rst = 1'b0;
      bus_read(2'd1, s);
      checks++;
      if (s !== 32'h2) begin
         failures++;
         $display("FAIL reset_status: got %h expected 00000002", s);
      end
   endtask

   task automatic test_register_reads();
      logic [31:0] s;
      logic [31:0] exp;
      clear_rx();
      for (int sel = 0; sel < 4; sel++) begin
         cpu_wdata = $urandom;
         bus_read(2'(sel), s);
         exp = (sel == 1) ? 32'h2 : 32'h0;
         checks++;
         if (s !== exp) begin
            failures++;
            $display("FAIL read_sel%0d: got %h expected %h", sel, s, exp);
         end
      end
      // Reserved writes and DATA writes without strobe bit 0 must not queue anything.
      bus_write(2'd2, 32'hFFFF_FFFF, 4'hF);
      bus_write(2'd3, 32'h0000_00A5, 4'hF);
      bus_write(2'd0, 32'h0000_005A, 4'hE);
      tick(30);
      bus_read(2'd1, s);
      checks++;
      if (s !== 32'h2 || busy !== 1'b0 || rx_q.size() != 0) begin
         failures++;
         $display("FAIL ignored_writes: got status %h busy %b frames %0d expected 00000002 0 0",
                  s, busy, rx_q.size());
      end
   endtask

   task automatic test_single_byte();
      logic [7:0] b;
      logic       exp_tx;
      logic       exp_busy;
      int         bad_tx;
      int         bad_busy;
      bit         to;
      b = 8'h55;
      bad_tx = 0;
      bad_busy = 0;
      clear_rx();
      bus_write(2'd0, {24'h0, b}, 4'h1);
      for (int k = 1; k <= 110; k++) begin
         tick(1);
         if (k < 2) exp_tx = 1'b1;
         else if (k < 2 + CPB) exp_tx = 1'b0;
         else if (k < 2 + 9 * CPB) exp_tx = b[(k - 2 - CPB) / CPB];
         else exp_tx = 1'b1;
         exp_busy = (k >= 1 && k <= 101);
         checks++;
         if (txd !== exp_tx) begin
            failures++;
            bad_tx++;
            if (bad_tx < 4) $display("FAIL single_tx k=%0d: got %b expected %b", k, txd, exp_tx);
         end
         checks++;
         if (busy !== exp_busy) begin
            failures++;
            bad_busy++;
            if (bad_busy < 4)
               $display("FAIL single_busy k=%0d: got %b expected %b", k, busy, exp_busy);
         end
      end
      wait_idle(50, to);
      checks++;
      if (to || rx_q.size() != 1 || rx_err != 0) begin
         failures++;
         $display("FAIL single_frames: got %0d frames err %0d timeout %0d expected 1 0 0",
                  rx_q.size(), rx_err, to);
      end else begin
         checks++;
         if (rx_q[0] !== b) begin
            failures++;
            $display("FAIL single_byte: got %h expected %h", rx_q[0], b);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit to;
      clear_rx();
      bus_write(2'd0, 32'hA5, 4'h1);
      bus_write(2'd0, 32'h3C, 4'h1);
      wait_idle(400, to);
      checks++;
      if (to || rx_q.size() != 2 || rx_err != 0) begin
         failures++;
         $display("FAIL b2b_frames: got %0d frames err %0d timeout %0d expected 2 0 0",
                  rx_q.size(), rx_err, to);
      end else begin
         checks++;
         if (rx_q[0] !== 8'hA5 || rx_q[1] !== 8'h3C) begin
            failures++;
            $display("FAIL b2b_bytes: got %h %h expected a5 3c", rx_q[0], rx_q[1]);
         end
         checks++;
         if (rx_start[1] - rx_start[0] != 10 * CPB) begin
            failures++;
            $display("FAIL b2b_gap: got %0d cycles expected %0d",
                     rx_start[1] - rx_start[0], 10 * CPB);
         end
      end
   endtask

   task automatic test_overflow();
      logic [7:0]  d[6];
      logic [31:0] s;
      bit          to;
      clear_rx();
      for (int i = 0; i < 6; i++) d[i] = 8'($urandom);
      for (int i = 0; i < 6; i++) bus_write(2'd0, {24'h0, d[i]}, 4'h1);
      bus_read(2'd1, s);
      checks++;
      if (s !== 32'h4D) begin
         failures++;
         $display("FAIL ovf_status: got %h expected 0000004d", s);
      end
      bus_write(2'd1, 32'h8, 4'h1);
      bus_read(2'd1, s);
      checks++;
      if (s !== 32'h45) begin
         failures++;
         $display("FAIL ovf_clear: got %h expected 00000045", s);
      end
      wait_idle(700, to);
      checks++;
      if (to || rx_q.size() != 5 || rx_err != 0) begin
         failures++;
         $display("FAIL ovf_frames: got %0d frames err %0d timeout %0d expected 5 0 0",
                  rx_q.size(), rx_err, to);
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (rx_q[i] !== d[i]) begin
               failures++;
               $display("FAIL ovf_byte%0d: got %h expected %h", i, rx_q[i], d[i]);
            end
         end
      end
   endtask

   task automatic test_full_pop_same_cycle();
      logic [7:0]  d[6];
      logic [31:0] s;
      bit          to;
      clear_rx();
      for (int i = 0; i < 6; i++) d[i] = 8'($urandom);
      // Writes at edges N..N+4: byte 0 is popped at N+1, bytes 1..4 fill the FIFO.
      for (int i = 0; i < 5; i++) bus_write(2'd0, {24'h0, d[i]}, 4'h1);
      bus_read(2'd1, s);
      checks++;
      if (s !== 32'h45) begin
         failures++;
         $display("FAIL fullpop_pre: got %h expected 00000045", s);
      end
      // First frame starts at N+1 and its stop ends with a pop at edge N+101.
      tick(95);
      bus_write(2'd0, {24'h0, d[5]}, 4'h1);
      bus_read(2'd1, s);
      checks++;
      if (s !== 32'h45) begin
         failures++;
         $display("FAIL fullpop_post: got %h expected 00000045", s);
      end
      wait_idle(800, to);
      checks++;
      if (to || rx_q.size() != 6 || rx_err != 0) begin
         failures++;
         $display("FAIL fullpop_frames: got %0d frames err %0d timeout %0d expected 6 0 0",
                  rx_q.size(), rx_err, to);
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (rx_q[i] !== d[i]) begin
               failures++;
               $display("FAIL fullpop_byte%0d: got %h expected %h", i, rx_q[i], d[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [7:0]  exp_q[$];
      logic [31:0] s;
      int          n;
      bit          to;
      for (int r = 0; r < 10; r++) begin
         clear_rx();
         exp_q.delete();
         // At most FIFO_DEPTH+1 bytes from idle: the first pops at once, so none drop.
         n = $urandom_range(1, DEPTH + 1);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0) begin
               case ($urandom_range(0, 2))
                  0: bus_write(2'($urandom_range(2, 3)), $urandom, 4'($urandom));
                  1: bus_write(2'd0, $urandom, {3'($urandom), 1'b0});
                  default: bus_write(2'd1, $urandom & 32'hFFFF_FFF7, 4'hF);
               endcase
            end
            s = $urandom;
            exp_q.push_back(s[7:0]);
            bus_write(2'd0, s, {3'($urandom), 1'b1});
            tick($urandom_range(0, 3));
         end
         wait_idle(10 * CPB * (DEPTH + 3), to);
         checks++;
         if (to || rx_q.size() != exp_q.size() || rx_err != 0) begin
            failures++;
            $display("FAIL rand%0d_frames: got %0d frames err %0d timeout %0d expected %0d 0 0",
                     r, rx_q.size(), rx_err, to, exp_q.size());
         end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
               checks++;
               if (rx_q[i] !== exp_q[i]) begin
                  failures++;
                  $display("FAIL rand%0d_byte%0d: got %h expected %h", r, i, rx_q[i], exp_q[i]);
               end
            end
         end
         bus_read(2'd1, s);
         checks++;
         if (s !== 32'h2) begin
            failures++;
            $display("FAIL rand%0d_status: got %h expected 00000002", r, s);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] s;
      int          bad;
      clear_rx();
      for (int i = 0; i < 3; i++) bus_write(2'd0, 32'($urandom_range(0, 255)), 4'h1);
      // Writes at N..N+2; data bit 3 is on the line for cycles N+42..N+51.
      tick(42);
      rst = 1'b1;
      tick(1);
      checks++;
      if (txd !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_tx: got %b expected 1", txd);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_busy: got %b expected 0", busy);
      end
      rst = 1'b0;
      bus_read(2'd1, s);
      checks++;
      if (s !== 32'h2) begin
         failures++;
         $display("FAIL rstmid_status: got %h expected 00000002", s);
      end
      // Let the receiver drain the aborted frame, then nothing more may appear.
      tick(150);
      clear_rx();
      bad = 0;
      for (int k = 0; k < 300; k++) begin
         tick(1);
         if (txd !== 1'b1 || busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0 || rx_q.size() != 0) begin
         failures++;
         $display("FAIL rstmid_quiet: got %0d active cycles %0d frames expected 0 0",
                  bad, rx_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_register_reads();
      test_single_byte();
      test_back_to_back();
      test_overflow();
      test_full_pop_same_cycle();
      test_random();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
